// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core pipeline sequencer.
package core_pkg;
    localparam int REG_W               = 5;
    localparam int CNT_W_DEFAULT       = 32;
    localparam int MEM_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-status inputs and stage-control outputs of the hazard sequencer.
interface hazard_ctrl_if import core_pkg::*; #(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [REG_W-1:0] Src1_ID;
    logic [REG_W-1:0] Src2_ID;
    logic             Two_Src_ID;
    logic [REG_W-1:0] Dst_EXE;
    logic             WB_EN_EXE;
    logic             MEM_R_EN_EXE;
    logic [REG_W-1:0] Dst_MEM;
    logic             WB_EN_MEM;
    logic             fwd_en;
    logic             Br_taken_EXE;
    logic             mem_req_MEM;
    logic             mem_ready;
    logic             freeze_IF;
    logic             freeze_ID;
    logic             bubble_ID;
    logic             flush_IF;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  Src1_ID, Src2_ID, Two_Src_ID, Dst_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               Dst_MEM, WB_EN_MEM, fwd_en, Br_taken_EXE, mem_req_MEM, mem_ready,
        output freeze_IF, freeze_ID, bubble_ID, flush_IF, freeze_back,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport master (
        output Src1_ID, Src2_ID, Two_Src_ID, Dst_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               Dst_MEM, WB_EN_MEM, fwd_en, Br_taken_EXE, mem_req_MEM, mem_ready,
        input  freeze_IF, freeze_ID, bubble_ID, flush_IF, freeze_back,
               mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between ID sources and EXE/MEM destinations.
module hazard_detect import core_pkg::*; (
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             two_src_i,
    input  logic [REG_W-1:0] dst_exe_i,
    input  logic             wb_en_exe_i,
    input  logic             mem_r_en_exe_i,
    input  logic [REG_W-1:0] dst_mem_i,
    input  logic             wb_en_mem_i,
    input  logic             fwd_en_i,
    output logic             raw_exe_o,
    output logic             raw_mem_o,
    output logic             hazard_o
);
    // r0 is hardwired to zero, so writes to it never carry a dependency.
    assign raw_exe_o = wb_en_exe_i && (dst_exe_i != '0) &&
                       ((dst_exe_i == src1_i) || (two_src_i && (dst_exe_i == src2_i)));
    assign raw_mem_o = wb_en_mem_i && (dst_mem_i != '0) &&
                       ((dst_mem_i == src1_i) || (two_src_i && (dst_mem_i == src2_i)));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard_o = fwd_en_i ? (raw_exe_o && mem_r_en_exe_i) : (raw_exe_o || raw_mem_o);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: memory-wait FSM with watchdog, branch/hazard priority and counters.
module hazard_ctrl import core_pkg::*; #(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);
    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_timeout_q;
    logic             raw_exe, raw_mem, hazard, mem_stall;
    logic             freeze_IF, freeze_ID, bubble_ID, flush_IF, freeze_back;

    hazard_detect u_detect (
        .src1_i         (bus.Src1_ID),
        .src2_i         (bus.Src2_ID),
        .two_src_i      (bus.Two_Src_ID),
        .dst_exe_i      (bus.Dst_EXE),
        .wb_en_exe_i    (bus.WB_EN_EXE),
        .mem_r_en_exe_i (bus.MEM_R_EN_EXE),
        .dst_mem_i      (bus.Dst_MEM),
        .wb_en_mem_i    (bus.WB_EN_MEM),
        .fwd_en_i       (bus.fwd_en),
        .raw_exe_o      (raw_exe),
        .raw_mem_o      (raw_mem),
        .hazard_o       (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req_MEM && !bus.mem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_d == WAIT_LAST) state_d = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = (state_q == IDLE && bus.mem_req_MEM && !bus.mem_ready) ||
                       (state_q == WAIT) || (state_q == ERR);

    // Frozen stages hold their contents, so branch and hazard resolve after the freeze.
    always_comb begin
        freeze_IF   = 1'b0;
        freeze_ID   = 1'b0;
        bubble_ID   = 1'b0;
        flush_IF    = 1'b0;
        freeze_back = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                freeze_IF   = 1'b1;
                freeze_ID   = 1'b1;
                freeze_back = 1'b1;
            end else if (bus.Br_taken_EXE) begin
                flush_IF  = 1'b1;
                bubble_ID = 1'b1;
            end else if (hazard) begin
                freeze_IF = 1'b1;
                bubble_ID = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (bubble_ID && !bus.Br_taken_EXE) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_IF) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            mem_timeout_q <= mem_timeout_q || (state_d == ERR);
        end
    end

    assign bus.freeze_IF   = freeze_IF;
    assign bus.freeze_ID   = freeze_ID;
    assign bus.bubble_ID   = bubble_ID;
    assign bus.flush_IF    = flush_IF;
    assign bus.freeze_back = freeze_back;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
    import core_pkg::*;
    localparam int MT = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();
    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nchk = 0;
    int nfail = 0;

    // Reference model: consecutive unready cycles of the current access, dead after timeout.
    int run = 0;
    bit dead = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) && (r == bus.Src1_ID || (bus.Two_Src_ID && r == bus.Src2_ID));
    endfunction

    task automatic idle_inputs();
        bus.Src1_ID = 0; bus.Src2_ID = 0; bus.Two_Src_ID = 0;
        bus.Dst_EXE = 0; bus.WB_EN_EXE = 0; bus.MEM_R_EN_EXE = 0;
        bus.Dst_MEM = 0; bus.WB_EN_MEM = 0; bus.fwd_en = 1;
        bus.Br_taken_EXE = 0; bus.mem_req_MEM = 0; bus.mem_ready = 0;
    endtask

    task automatic model_reset();
        run = 0; dead = 0; m_stall = 0; m_flush = 0;
    endtask

    // Inputs must already be applied; checks at negedge, advances the model after posedge.
    task automatic step(input string tag);
        bit busy, dep_exe, dep_mem, haz;
        bit e_fif, e_fid, e_bub, e_fl, e_fb;
        @(negedge clk);
        busy    = dead || run > 0 || (bus.mem_req_MEM && !bus.mem_ready);
        dep_exe = bus.WB_EN_EXE && reads(bus.Dst_EXE);
        dep_mem = bus.WB_EN_MEM && reads(bus.Dst_MEM);
        haz     = bus.fwd_en ? (dep_exe && bus.MEM_R_EN_EXE) : (dep_exe || dep_mem);
        e_fif = busy || (!bus.Br_taken_EXE && haz);
        e_fid = busy;
        e_fb  = busy;
        e_fl  = !busy && bus.Br_taken_EXE;
        e_bub = !busy && (bus.Br_taken_EXE || haz);
        check({tag, ".freeze_IF"},   32'(bus.freeze_IF),   32'(e_fif));
        check({tag, ".freeze_ID"},   32'(bus.freeze_ID),   32'(e_fid));
        check({tag, ".bubble_ID"},   32'(bus.bubble_ID),   32'(e_bub));
        check({tag, ".flush_IF"},    32'(bus.flush_IF),    32'(e_fl));
        check({tag, ".freeze_back"}, 32'(bus.freeze_back), 32'(e_fb));
        check({tag, ".mem_timeout"}, 32'(bus.mem_timeout), 32'(dead));
        check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   32'(m_stall));
        check({tag, ".flush_cnt"},   32'(bus.flush_cnt),   32'(m_flush));
        @(posedge clk);
        #1;
        if (e_bub && !bus.Br_taken_EXE) m_stall = (m_stall + 1) % (1 << CW);
        if (e_fl) m_flush = (m_flush + 1) % (1 << CW);
        if (!dead) begin
            if (run > 0) begin
                if (bus.mem_ready) run = 0;
                else begin
                    run++;
                    if (run >= MT - 1) dead = 1;
                end
            end else if (bus.mem_req_MEM && !bus.mem_ready) run = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".freeze_IF"},   32'(bus.freeze_IF),   0);
        check({tag, ".freeze_ID"},   32'(bus.freeze_ID),   0);
        check({tag, ".bubble_ID"},   32'(bus.bubble_ID),   0);
        check({tag, ".flush_IF"},    32'(bus.flush_IF),    0);
        check({tag, ".freeze_back"}, 32'(bus.freeze_back), 0);
        check({tag, ".mem_timeout"}, 32'(bus.mem_timeout), 0);
        check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   0);
        check({tag, ".flush_cnt"},   32'(bus.flush_cnt),   0);
    endtask

    initial begin
        logic [CW-1:0] saved;
        // Reset with inputs that would otherwise stall and flush.
        idle_inputs();
        rst = 1'b1;
        bus.MEM_R_EN_EXE = 1; bus.WB_EN_EXE = 1; bus.Dst_EXE = 5; bus.Src1_ID = 5;
        bus.Br_taken_EXE = 1; bus.mem_req_MEM = 1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step("idle");

        // Load-use with forwarding: exactly one bubble once the load moves on.
        bus.MEM_R_EN_EXE = 1; bus.WB_EN_EXE = 1; bus.Dst_EXE = 5; bus.Src1_ID = 5;
        step("load_use");
        idle_inputs(); bus.Src1_ID = 5; bus.Dst_MEM = 5; bus.WB_EN_MEM = 1;
        step("load_use_after");
        check("load_use.stall_cnt1", 32'(bus.stall_cnt), 1);

        // Forwarding off: MEM-stage dependency through Src2.
        idle_inputs(); bus.fwd_en = 0; bus.WB_EN_MEM = 1; bus.Dst_MEM = 7;
        bus.Src2_ID = 7; bus.Two_Src_ID = 1;
        step("nofwd_src2");
        bus.Two_Src_ID = 0;
        step("nofwd_one_src");
        bus.Two_Src_ID = 1; bus.Dst_MEM = 0; bus.Src2_ID = 0;
        step("nofwd_r0");
        bus.fwd_en = 1; bus.Dst_MEM = 7; bus.Src2_ID = 7;
        step("fwd_mem_only");

        // Taken branch outranks a load-use hazard.
        idle_inputs(); bus.MEM_R_EN_EXE = 1; bus.WB_EN_EXE = 1; bus.Dst_EXE = 5;
        bus.Src1_ID = 5; bus.Br_taken_EXE = 1;
        step("br_vs_haz");
        check("br_vs_haz.flush_cnt1", 32'(bus.flush_cnt), 1);

        // Memory wait of three unready cycles with a branch pending behind it.
        idle_inputs(); bus.mem_req_MEM = 1; bus.Br_taken_EXE = 1;
        for (int i = 0; i < 3; i++) step($sformatf("memwait%0d", i));
        bus.mem_ready = 1;
        step("memwait_done");
        bus.mem_req_MEM = 0; bus.mem_ready = 0;
        step("memwait_release");
        idle_inputs();

        // Sixteen stall cycles bring the narrow counter back to its start value.
        saved = bus.stall_cnt;
        bus.fwd_en = 0; bus.WB_EN_EXE = 1; bus.Dst_EXE = 3; bus.Src1_ID = 3;
        for (int i = 0; i < 16; i++) step($sformatf("wrap%0d", i));
        idle_inputs();
        step("wrap_end");
        check("wrap.stall_cnt", 32'(bus.stall_cnt), 32'(saved));

        // Random traffic with a mostly-ready memory.
        for (int i = 0; i < 400; i++) begin
            bus.Src1_ID      = 5'($urandom_range(0, 7));
            bus.Src2_ID      = 5'($urandom_range(0, 7));
            bus.Two_Src_ID   = 1'($urandom);
            bus.Dst_EXE      = 5'($urandom_range(0, 7));
            bus.WB_EN_EXE    = 1'($urandom);
            bus.MEM_R_EN_EXE = 1'($urandom);
            bus.Dst_MEM      = 5'($urandom_range(0, 7));
            bus.WB_EN_MEM    = 1'($urandom);
            bus.fwd_en       = 1'($urandom);
            bus.Br_taken_EXE = ($urandom_range(0, 3) == 0);
            bus.mem_req_MEM  = ($urandom_range(0, 2) == 0);
            bus.mem_ready    = ($urandom_range(0, 3) != 0);
            step($sformatf("rand%0d", i));
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Watchdog: memory never answers.
        bus.mem_req_MEM = 1; bus.mem_ready = 0;
        for (int i = 0; i < 10; i++) step($sformatf("timeout%0d", i));
        check("timeout.flag", 32'(bus.mem_timeout), 1);
        check("timeout.freeze", 32'(bus.freeze_back), 1);

        // Asynchronous reset in the middle of ERR.
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_in_err");
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step("after_rst");
        bus.MEM_R_EN_EXE = 1; bus.WB_EN_EXE = 1; bus.Dst_EXE = 9; bus.Src2_ID = 9;
        bus.Two_Src_ID = 1;
        step("after_rst_haz");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
